// File: rtl/sos_pulse_tx.sv
// sos_pulse_tx: transmit side of the speed-of-sound ranging path.
// On a one-cycle request it mutes program audio and plays a quiet / pulse / holdoff
// sequence on the 24 kHz speaker sample stream. It marks the first pulse sample with
// impulse_out so the mic side can start counting sample periods.
// Optional build macro: SOS_PULSE_TX_BIPOLAR_EN selects a zero-DC doublet pulse
// (+A for the first half, -A for the second half) instead of a unipolar rectangle.
module sos_pulse_tx #(
  parameter int unsigned        QUIET_LEN   = 4,
  parameter int unsigned        PULSE_LEN   = 4,
  parameter int unsigned        HOLDOFF_LEN = 8,
  parameter logic signed [15:0] AMPLITUDE   = 16'sd24000
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               step_in,
  input  logic               impulse_in,
  input  logic signed [15:0] audio_in,
  output logic signed [15:0] amp_out,
  output logic               impulse_out,
  output logic               busy_out,
  output logic               done_out,
  output logic               req_dropped_out
);

  localparam int unsigned MaxQp  = (QUIET_LEN > PULSE_LEN) ? QUIET_LEN : PULSE_LEN;
  localparam int unsigned MaxLen = (MaxQp > HOLDOFF_LEN) ? MaxQp : HOLDOFF_LEN;
  localparam int unsigned CntW   = $clog2(MaxLen) + 1;

  // AMPLITUDE <= 32767, so the 16-bit negation cannot overflow.
  localparam logic signed [15:0] AmpNeg = -AMPLITUDE;

  // Elaboration-time parameter sanity checks.
  if (QUIET_LEN < 1) begin : g_bad_quiet
    $error("QUIET_LEN must be at least 1");
  end
  if (PULSE_LEN < 1) begin : g_bad_pulse
    $error("PULSE_LEN must be at least 1");
  end
  if (HOLDOFF_LEN < 1) begin : g_bad_holdoff
    $error("HOLDOFF_LEN must be at least 1");
  end
  if (AMPLITUDE < 16'sd1) begin : g_bad_amp
    $error("AMPLITUDE must be in 1..32767");
  end
`ifdef SOS_PULSE_TX_BIPOLAR_EN
  if ((PULSE_LEN % 2) != 0) begin : g_bad_pulse_odd
    $error("PULSE_LEN must be even for the bipolar pulse");
  end
`endif

  typedef enum logic [1:0] {StIdle, StQuiet, StPulse, StHoldoff} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic signed [15:0]   amp_q, amp_d;
  logic                 impulse_q, impulse_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dropped_q, dropped_d;
  logic signed [15:0]   pulse_sample;

  // Pulse shape for sample index k = cnt_q.
  always_comb begin
    pulse_sample = AMPLITUDE;
`ifdef SOS_PULSE_TX_BIPOLAR_EN
    if (cnt_q >= CntW'(PULSE_LEN / 2)) begin
      pulse_sample = AmpNeg;
    end
`endif
  end

  // Sequencer next-state, counter and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    amp_d     = amp_q;
    impulse_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dropped_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (step_in) begin
          amp_d = audio_in;
        end
        // A request coincident with a step still takes the passthrough sample.
        if (impulse_in) begin
          state_d = StQuiet;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StQuiet: begin
        if (step_in) begin
          amp_d = '0;
          if (cnt_q == CntW'(QUIET_LEN - 1)) begin
            state_d = StPulse;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StPulse: begin
        if (step_in) begin
          amp_d     = pulse_sample;
          impulse_d = (cnt_q == '0);
          if (cnt_q == CntW'(PULSE_LEN - 1)) begin
            state_d = StHoldoff;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHoldoff: begin
        if (step_in) begin
          amp_d = '0;
          if (cnt_q == CntW'(HOLDOFF_LEN - 1)) begin
            state_d = StIdle;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Requests outside IDLE are dropped; the running sequence is untouched.
    if (impulse_in && (state_q != StIdle)) begin
      dropped_d = 1'b1;
    end
  end

  // State and output registers; reset silences the speaker immediately.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      amp_q     <= '0;
      impulse_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      amp_q     <= amp_d;
      impulse_q <= impulse_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
    end
  end

  assign amp_out         = amp_q;
  assign impulse_out     = impulse_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign req_dropped_out = dropped_q;

endmodule

// File: tb/tb_sos_pulse_tx.sv
// Directed testbench for sos_pulse_tx with Q=4, P=4, H=8, A=24000, step every 10 clocks.
module tb_sos_pulse_tx;

  logic               clk_in = 1'b0;
  logic               rst_n_in = 1'b0;
  logic               step_in = 1'b0;
  logic               impulse_in = 1'b0;
  logic signed [15:0] audio_in = '0;
  logic signed [15:0] amp_out;
  logic               impulse_out;
  logic               busy_out;
  logic               done_out;
  logic               req_dropped_out;

  int n_checks = 0;
  int n_fail   = 0;

  sos_pulse_tx #(
    .QUIET_LEN  (4),
    .PULSE_LEN  (4),
    .HOLDOFF_LEN(8),
    .AMPLITUDE  (16'sd24000)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .step_in        (step_in),
    .impulse_in     (impulse_in),
    .audio_in       (audio_in),
    .amp_out        (amp_out),
    .impulse_out    (impulse_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .req_dropped_out(req_dropped_out)
  );

  always #5 clk_in = ~clk_in;

  // Expected pulse sample k (0..3).
  function automatic logic signed [15:0] exp_pulse(input int k);
`ifdef SOS_PULSE_TX_BIPOLAR_EN
    return (k < 2) ? 16'sd24000 : -16'sd24000;
`else
    return 16'sd24000;
`endif
  endfunction

  // Expected amp_out at step i (0-based) after acceptance of a request.
  function automatic logic signed [15:0] exp_seq(input int i);
    if (i >= 4 && i < 8) return exp_pulse(i - 4);
    return 16'sd0;
  endfunction

  // Called at posedge+1; issues one step after 9 idle clocks, returns at posedge+1.
  task automatic do_step(input logic signed [15:0] a, input logic imp);
    repeat (9) @(posedge clk_in);
    #1;
    step_in    = 1'b1;
    audio_in   = a;
    impulse_in = imp;
    @(posedge clk_in);
    #1;
    step_in    = 1'b0;
    impulse_in = 1'b0;
  endtask

  // One-cycle request with no step.
  task automatic request();
    impulse_in = 1'b1;
    @(posedge clk_in);
    #1;
    impulse_in = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    n_checks++;
    if (amp_out !== 16'sd0 || impulse_out !== 1'b0 || busy_out !== 1'b0 ||
        done_out !== 1'b0 || req_dropped_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got amp=%0d imp=%b busy=%b done=%b drop=%b want all 0",
               amp_out, impulse_out, busy_out, done_out, req_dropped_out);
    end
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_passthrough_and_sequence();
    logic signed [15:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 16'(i * 1000 - 1500);
      do_step(a, 1'b0);
      n_checks++;
      if (amp_out !== a || busy_out !== 1'b0) begin
        n_fail++;
        $display("FAIL passthrough[%0d]: got amp=%0d busy=%b want amp=%0d busy=0",
                 i, amp_out, busy_out, a);
      end
    end
    request();
    n_checks++;
    if (busy_out !== 1'b1 || amp_out !== 16'sd500) begin
      n_fail++;
      $display("FAIL accept_idle: got busy=%b amp=%0d want busy=1 amp=500", busy_out, amp_out);
    end
    for (int i = 0; i < 16; i++) begin
      do_step(16'(7000 + i), 1'b0);
      n_checks++;
      if (amp_out !== exp_seq(i) || impulse_out !== (i == 4) || done_out !== (i == 15) ||
          busy_out !== (i != 15)) begin
        n_fail++;
        $display("FAIL seq_step[%0d]: got amp=%0d imp=%b done=%b busy=%b want amp=%0d imp=%b done=%b busy=%b",
                 i, amp_out, impulse_out, done_out, busy_out, exp_seq(i), (i == 4), (i == 15),
                 (i != 15));
      end
      if (i == 4 || i == 15) begin
        @(posedge clk_in);
        #1;
        n_checks++;
        if (impulse_out !== 1'b0 || done_out !== 1'b0) begin
          n_fail++;
          $display("FAIL strobe_width[%0d]: got imp=%b done=%b want 0 0", i, impulse_out, done_out);
        end
      end
    end
    do_step(16'sd1234, 1'b0);
    n_checks++;
    if (amp_out !== 16'sd1234) begin
      n_fail++;
      $display("FAIL resume_audio: got %0d want 1234", amp_out);
    end
  endtask

  task automatic test_drop_in_pulse();
    request();
    for (int i = 0; i < 16; i++) begin
      do_step(16'(-5 - i), (i == 5));
      n_checks++;
      if (amp_out !== exp_seq(i) || impulse_out !== (i == 4) || req_dropped_out !== (i == 5) ||
          done_out !== (i == 15)) begin
        n_fail++;
        $display("FAIL drop_step[%0d]: got amp=%0d imp=%b drop=%b done=%b want amp=%0d imp=%b drop=%b done=%b",
                 i, amp_out, impulse_out, req_dropped_out, done_out, exp_seq(i), (i == 4),
                 (i == 5), (i == 15));
      end
      if (i == 5) begin
        @(posedge clk_in);
        #1;
        n_checks++;
        if (req_dropped_out !== 1'b0 || busy_out !== 1'b1) begin
          n_fail++;
          $display("FAIL drop_width: got drop=%b busy=%b want 0 1", req_dropped_out, busy_out);
        end
      end
    end
    do_step(16'sd77, 1'b0);
    n_checks++;
    if (amp_out !== 16'sd77 || impulse_out !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_resume: got amp=%0d imp=%b want 77 0", amp_out, impulse_out);
    end
  endtask

  task automatic test_coincident();
    do_step(16'sd555, 1'b1);
    n_checks++;
    if (amp_out !== 16'sd555 || busy_out !== 1'b1) begin
      n_fail++;
      $display("FAIL coincident_accept: got amp=%0d busy=%b want 555 1", amp_out, busy_out);
    end
    for (int i = 0; i < 16; i++) begin
      do_step(16'sd999, 1'b0);
      n_checks++;
      if (amp_out !== exp_seq(i) || done_out !== (i == 15)) begin
        n_fail++;
        $display("FAIL coincident_step[%0d]: got amp=%0d done=%b want amp=%0d done=%b",
                 i, amp_out, done_out, exp_seq(i), (i == 15));
      end
    end
  endtask

  task automatic test_stall();
    request();
    do_step(16'sd321, 1'b0);
    do_step(16'sd321, 1'b0);
    repeat (100) @(posedge clk_in);
    #1;
    n_checks++;
    if (amp_out !== 16'sd0 || busy_out !== 1'b1 || impulse_out !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: got amp=%0d busy=%b imp=%b want 0 1 0",
               amp_out, busy_out, impulse_out);
    end
    for (int i = 2; i < 16; i++) begin
      do_step(16'sd321, 1'b0);
      n_checks++;
      if (amp_out !== exp_seq(i) || impulse_out !== (i == 4) || done_out !== (i == 15)) begin
        n_fail++;
        $display("FAIL stall_step[%0d]: got amp=%0d imp=%b done=%b want amp=%0d imp=%b done=%b",
                 i, amp_out, impulse_out, done_out, exp_seq(i), (i == 4), (i == 15));
      end
    end
  endtask

  task automatic test_async_reset();
    request();
    for (int i = 0; i < 6; i++) begin
      do_step(16'sd42, 1'b0);
    end
    n_checks++;
    if (amp_out !== exp_pulse(1)) begin
      n_fail++;
      $display("FAIL pre_reset_pulse: got %0d want %0d", amp_out, exp_pulse(1));
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    n_checks++;
    if (amp_out !== 16'sd0 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got amp=%0d busy=%b want 0 0", amp_out, busy_out);
    end
    repeat (2) @(posedge clk_in);
    #3;
    rst_n_in   = 1'b1;
    impulse_in = 1'b1;
    @(posedge clk_in);
    #1;
    impulse_in = 1'b0;
    n_checks++;
    if (busy_out !== 1'b1 || done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_accept: got busy=%b done=%b want 1 0", busy_out, done_out);
    end
    for (int i = 0; i < 16; i++) begin
      do_step(16'sd42, 1'b0);
      n_checks++;
      if (amp_out !== exp_seq(i) || impulse_out !== (i == 4) || done_out !== (i == 15)) begin
        n_fail++;
        $display("FAIL post_reset_step[%0d]: got amp=%0d imp=%b done=%b want amp=%0d imp=%b done=%b",
                 i, amp_out, impulse_out, done_out, exp_seq(i), (i == 4), (i == 15));
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough_and_sequence();
    test_drop_in_pulse();
    test_coincident();
    test_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
